// File: rtl/scpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scpu_pkg
//  Description : Shared SCPU definitions: bus widths, opcode constants used
//                by the CPU core, and the data-memory controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package scpu_pkg;

    // CPU data-port widths
    localparam int SCPU_ADDR_W = 13;
    localparam int SCPU_DATA_W = 16;

    // Opcode constants shared with the CPU decoder
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Data-memory controller states
    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        IDLE     = 2'd1,
        HOST_ACK = 2'd2
    } dmem_state_t;

endpackage : scpu_pkg
`default_nettype wire

// File: rtl/scpu_dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : scpu_dmem_ram
//  Description : Single-port synchronous RAM. One access per enabled edge:
//                a write stores wdata, a read loads rdata. rdata is held
//                across writes and idle cycles, so it only changes on reads.
//  Ports       : clk   - clock
//                en    - access enable
//                we    - 1 = write, 0 = read (when en=1)
//                addr  - word address
//                wdata - write data
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module scpu_dmem_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8192,
    parameter int AW     = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : scpu_dmem_ram
`default_nettype wire

// File: rtl/scpu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : scpu_dmem
//  Description : SCPU data-memory responder. Serves the CPU data port with a
//                1-cycle registered read latency and store write-through,
//                gives a host port access while the CPU is idle, and can
//                sweep the array to zero after reset.
//                Port priority: CLEAR > CPU > host.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                WEN, ADDR, MEM_in   - CPU request (WEN=0 store, 1 load)
//                MEM_out             - CPU load / write-through data
//                cpu_en              - CPU port active, locks out the host
//                host_req/we/addr/wdata - host request, held until ack
//                host_rdata, host_ack   - host completion
//                init_done           - memory usable
//  Revision    : 1.0 - initial release
// ============================================================================
module scpu_dmem
    import scpu_pkg::*;
#(
    parameter int ADDR_W         = SCPU_ADDR_W,
    parameter int DATA_W         = SCPU_DATA_W,
    parameter int DEPTH          = 8192,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] MEM_in,
    output logic [DATA_W-1:0] MEM_out,
    input  logic              cpu_en,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              init_done
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(DEPTH - 1);
    localparam dmem_state_t RST_STATE =
        (CLEAR_ON_RESET != 0) ? dmem_state_t'(CLEAR) : dmem_state_t'(IDLE);

    dmem_state_t       state;
    dmem_state_t       state_next;
    logic [RAM_AW-1:0] cnt;

    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Each output is either a held register or, in the cycle right after a
    // RAM read, the RAM's own output register. The *_from_ram flag selects
    // the live RAM data, and on the following edge that data is copied into
    // the holding register so the shared RAM read port can be reused.
    logic [DATA_W-1:0] mem_out_q;
    logic              mem_out_from_ram;
    logic [DATA_W-1:0] host_rdata_q;
    logic              host_rdata_from_ram;

    logic cpu_active;
    logic cpu_hit;
    logic host_accept;
    logic host_hit;
    logic clear_last;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    assign cpu_active  = (state != CLEAR) && cpu_en;
    assign cpu_hit     = in_range(ADDR);
    assign host_accept = (state == IDLE) && host_req && !cpu_en;
    assign host_hit    = in_range(host_addr);
    assign clear_last  = (cnt == LAST_ADDR);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: begin
                if (clear_last) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (host_accept) begin
                    state_next = HOST_ACK;
                end
            end
            HOST_ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = RST_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / RAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            CLEAR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt;
            end
            default: begin
                // Out-of-range accesses never reach the RAM.
                if (cpu_en) begin
                    if (cpu_hit) begin
                        ram_en    = 1'b1;
                        ram_we    = ~WEN;
                        ram_addr  = ADDR[RAM_AW-1:0];
                        ram_wdata = MEM_in;
                    end
                end else if (host_accept && host_hit) begin
                    ram_en    = 1'b1;
                    ram_we    = host_we;
                    ram_addr  = host_addr[RAM_AW-1:0];
                    ram_wdata = host_wdata;
                end
            end
        endcase
    end

    assign host_ack = (state == HOST_ACK);

    // ------------------------------------------------------------------
    // Clear counter, init flag and output holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt                 <= '0;
            init_done           <= 1'b0;
            mem_out_q           <= '0;
            mem_out_from_ram    <= 1'b0;
            host_rdata_q        <= '0;
            host_rdata_from_ram <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                cnt <= cnt + RAM_AW'(1);
            end
            if (state_next != CLEAR) begin
                init_done <= 1'b1;
            end

            // CPU side: load selects RAM data, store forwards MEM_in.
            // An out-of-range word reads as 0, including the write-through.
            if (mem_out_from_ram) begin
                mem_out_q <= ram_rdata;
            end
            mem_out_from_ram <= 1'b0;
            if (cpu_active) begin
                if (WEN) begin
                    if (cpu_hit) begin
                        mem_out_from_ram <= 1'b1;
                    end else begin
                        mem_out_q <= '0;
                    end
                end else begin
                    mem_out_q <= cpu_hit ? MEM_in : '0;
                end
            end

            // Host side: only reads update host_rdata.
            if (host_rdata_from_ram) begin
                host_rdata_q <= ram_rdata;
            end
            host_rdata_from_ram <= 1'b0;
            if (host_accept && !host_we) begin
                if (host_hit) begin
                    host_rdata_from_ram <= 1'b1;
                end else begin
                    host_rdata_q <= '0;
                end
            end
        end
    end

    assign MEM_out    = mem_out_from_ram    ? ram_rdata : mem_out_q;
    assign host_rdata = host_rdata_from_ram ? ram_rdata : host_rdata_q;

    scpu_dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule : scpu_dmem
`default_nettype wire

// File: tb/tb_scpu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scpu_dmem
//  Description : Bench for scpu_dmem. A small instance (DEPTH=16, clear on
//                reset) is checked every cycle against a transaction-level
//                model; a full-size instance without clear covers addresses
//                beyond 16 and the no-clear start-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scpu_dmem;

    localparam int AW      = 13;
    localparam int DW      = 16;
    localparam int DEPTH_S = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          WEN;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] MEM_in;
    logic [DW-1:0] MEM_out;
    logic          cpu_en;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          init_done;

    // Full-size instance signals
    logic          b_WEN;
    logic [AW-1:0] b_ADDR;
    logic [DW-1:0] b_MEM_in;
    logic [DW-1:0] b_MEM_out;
    logic          b_cpu_en;
    logic          b_host_req;
    logic          b_host_we;
    logic [AW-1:0] b_host_addr;
    logic [DW-1:0] b_host_wdata;
    logic [DW-1:0] b_host_rdata;
    logic          b_host_ack;
    logic          b_init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scpu_dmem #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH_S), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .WEN(WEN), .ADDR(ADDR), .MEM_in(MEM_in),
        .MEM_out(MEM_out), .cpu_en(cpu_en), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack), .init_done(init_done)
    );

    scpu_dmem #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(8192), .CLEAR_ON_RESET(0)
    ) dut_big (
        .clk(clk), .rst_n(rst_n), .WEN(b_WEN), .ADDR(b_ADDR), .MEM_in(b_MEM_in),
        .MEM_out(b_MEM_out), .cpu_en(b_cpu_en), .host_req(b_host_req),
        .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
        .host_rdata(b_host_rdata), .host_ack(b_host_ack), .init_done(b_init_done)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model of the small instance.
    // After reset the memory is zeroed one word per cycle; afterwards each
    // cycle is one CPU access (if cpu_en) or one host access (if the host
    // is requesting and the previous cycle was not an ack cycle).
    // ------------------------------------------------------------------
    logic [DW-1:0] mdl_mem [DEPTH_S];
    int            m_clr_left;
    logic          m_ready;
    logic          m_ack;
    logic [DW-1:0] m_mem_out;
    logic [DW-1:0] m_host_rdata;

    function automatic logic hit(input logic [AW-1:0] a);
        return (int'(a) < DEPTH_S);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clr_left   <= DEPTH_S;
            m_ready      <= 1'b0;
            m_ack        <= 1'b0;
            m_mem_out    <= '0;
            m_host_rdata <= '0;
        end else if (m_clr_left > 0) begin
            mdl_mem[DEPTH_S - m_clr_left] <= '0;
            m_clr_left <= m_clr_left - 1;
            m_ready    <= (m_clr_left == 1);
        end else begin
            m_ready <= 1'b1;
            m_ack   <= 1'b0;
            if (cpu_en) begin
                if (WEN) begin
                    m_mem_out <= hit(ADDR) ? mdl_mem[ADDR[3:0]] : '0;
                end else begin
                    if (hit(ADDR)) mdl_mem[ADDR[3:0]] <= MEM_in;
                    m_mem_out <= hit(ADDR) ? MEM_in : '0;
                end
            end else if (host_req && !m_ack) begin
                m_ack <= 1'b1;
                if (host_we) begin
                    if (hit(host_addr)) mdl_mem[host_addr[3:0]] <= host_wdata;
                end else begin
                    m_host_rdata <= hit(host_addr) ? mdl_mem[host_addr[3:0]] : '0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("mem_out", MEM_out, m_mem_out);
        check("host_rdata", host_rdata, m_host_rdata);
        check("host_ack", {15'd0, host_ack}, {15'd0, m_ack});
        check("init_done", {15'd0, init_done}, {15'd0, m_ready});
    end

    // Host transaction on the small instance; call right after a negedge.
    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output int lat);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        lat = 0; rd = '0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = i;
                rd  = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        if (lat == 0) begin
            errors++; checks++;
            $display("FAIL host_timeout: no ack for addr %h", a);
        end
    endtask

    task automatic cpu_cycle(input logic en, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_en = en; WEN = wen; ADDR = a; MEM_in = d;
        @(negedge clk);
    endtask

    task automatic big_cycle(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        b_cpu_en = 1'b1; b_WEN = wen; b_ADDR = a; b_MEM_in = d;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int lat, cyc, done_cyc, ack_cyc;

        rst_n = 1'b0;
        WEN = 1'b1; ADDR = '0; MEM_in = '0; cpu_en = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        b_WEN = 1'b1; b_ADDR = '0; b_MEM_in = '0; b_cpu_en = 1'b0;
        b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = '0; b_host_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_out", MEM_out, 16'h0000);
        check("rst_host_ack", {15'd0, host_ack}, 16'h0000);
        check("rst_init_done", {15'd0, init_done}, 16'h0000);
        check("rst_big_init_done", {15'd0, b_init_done}, 16'h0000);

        // Release reset with a host read of addr 5 already pending.
        rst_n = 1'b1;
        host_we = 1'b0; host_addr = 13'd5; host_req = 1'b1;
        done_cyc = 0; ack_cyc = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("big_init_first_edge", {15'd0, b_init_done}, 16'h0001);
            if (init_done && done_cyc == 0) done_cyc = cyc;
            if (host_ack) begin
                ack_cyc = cyc;
                rd = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        check("init_done_edge", 16'(done_cyc), 16'd16);
        check("clear_host_ack_cycle", 16'(ack_cyc), 16'd17);
        check("clear_host_rdata", rd, 16'h0000);

        // Full-size instance: store / write-through / load
        big_cycle(1'b0, 13'h0010, 16'hBEEF);
        check("big_store_wt", b_MEM_out, 16'hBEEF);
        big_cycle(1'b1, 13'h0010, 16'h0000);
        check("big_load", b_MEM_out, 16'hBEEF);
        big_cycle(1'b0, 13'h0011, 16'h1234);
        check("big_store2_wt", b_MEM_out, 16'h1234);
        big_cycle(1'b1, 13'h0010, 16'h0000);
        check("big_reload", b_MEM_out, 16'hBEEF);
        b_cpu_en = 1'b0;
        @(negedge clk);
        check("big_hold", b_MEM_out, 16'hBEEF);

        // Repeated stores to one address
        cpu_cycle(1'b1, 1'b0, 13'd2, 16'h0001);
        cpu_cycle(1'b1, 1'b0, 13'd2, 16'h0002);
        cpu_cycle(1'b1, 1'b0, 13'd2, 16'h0003);
        cpu_cycle(1'b1, 1'b1, 13'd2, 16'h0000);
        check("multi_store_load", MEM_out, 16'h0003);

        // Host write, one-cycle ack, host read, CPU load
        cpu_en = 1'b0;
        host_op(1'b1, 13'd3, 16'hFFFB, rd, lat);
        check("host_wr_lat", 16'(lat), 16'd1);
        @(negedge clk);
        check("host_ack_one_cycle", {15'd0, host_ack}, 16'h0000);
        host_op(1'b0, 13'd3, 16'h0000, rd, lat);
        check("host_rd_data", rd, 16'hFFFB);
        @(negedge clk);
        check("host_rdata_hold", host_rdata, 16'hFFFB);
        cpu_cycle(1'b1, 1'b1, 13'd3, 16'h0000);
        check("cpu_load_host_data", MEM_out, 16'hFFFB);

        // Host locked out while the CPU is active
        host_we = 1'b0; host_addr = 13'd2; host_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_cycle(1'b1, 1'b1, 13'd2, 16'h0000);
            if (host_ack) lat++;
        end
        check("no_ack_while_cpu", 16'(lat), 16'd0);
        cpu_en = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (host_ack) begin lat = i; break; end
        end
        host_req = 1'b0;
        check("ack_after_cpu_drop", 16'(lat), 16'd1);
        check("locked_host_rdata", host_rdata, 16'h0003);

        // Out-of-range CPU access (addr 20 aliases word 4 if decoded wrongly)
        cpu_cycle(1'b1, 1'b0, 13'd4, 16'h4444);
        cpu_cycle(1'b1, 1'b0, 13'd20, 16'h5555);
        cpu_cycle(1'b1, 1'b1, 13'd20, 16'h0000);
        check("oor_load", MEM_out, 16'h0000);
        cpu_cycle(1'b1, 1'b1, 13'd4, 16'h0000);
        check("oor_no_alias", MEM_out, 16'h4444);

        // Randomized traffic
        cpu_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cpu_en = ($urandom_range(0, 99) < 55);
            WEN    = $urandom_range(0, 1);
            ADDR   = 13'($urandom_range(0, 23));
            MEM_in = 16'($urandom);
            if (host_req && host_ack) begin
                host_req = 1'b0;
            end else if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = $urandom_range(0, 1);
                host_addr  = 13'($urandom_range(0, 23));
                host_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        host_req = 1'b0;
        cpu_en = 1'b0;
        @(negedge clk);

        // Reset during HOST_ACK: MEM_out nonzero first, then reset mid-ack
        cpu_cycle(1'b1, 1'b0, 13'd7, 16'hA5A5);
        cpu_en = 1'b0;
        host_we = 1'b0; host_addr = 13'd7; host_req = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (host_ack) begin lat = i; break; end
        end
        check("pre_rst_ack", 16'(lat), 16'd1);
        check("pre_rst_mem_out", MEM_out, 16'hA5A5);
        #2;
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        check("midrst_host_ack", {15'd0, host_ack}, 16'h0000);
        check("midrst_mem_out", MEM_out, 16'h0000);
        check("midrst_init_done", {15'd0, init_done}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        done_cyc = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (init_done) begin done_cyc = cyc; break; end
        end
        check("reclear_done_edge", 16'(done_cyc), 16'd16);
        host_op(1'b0, 13'd7, 16'h0000, rd, lat);
        check("reclear_zeroed", rd, 16'h0000);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_scpu_dmem
`default_nettype wire
